// File: rtl/lscc_rst_seq_if.sv
// Control and status bundle between the reset sequencer and the logic it drives.
// The master side drives hold/soft-retrigger and observes the per-channel resets.
interface lscc_rst_seq_if #(
   parameter int NUM_CH = 4
) ();
   logic              hold_i;
   logic              soft_rst_i;
   logic [NUM_CH-1:0] rst_o;
   logic [NUM_CH-1:0] rst_n_o;
   logic              done_o;
   logic              timeout_o;

   modport master (
      output hold_i,
      output soft_rst_i,
      input  rst_o,
      input  rst_n_o,
      input  done_o,
      input  timeout_o
   );

   modport slave (
      input  hold_i,
      input  soft_rst_i,
      output rst_o,
      output rst_n_o,
      output done_o,
      output timeout_o
   );
endinterface

// File: rtl/lscc_rst_seq.sv
// Staggered multi-channel reset sequencer: synchronises rst_i release, then frees
// channel k D_k = BASE_DELAY + k*STAGGER cycles into COUNT, with hold, soft retrigger and watchdog.
module lscc_rst_seq #(
   parameter int NUM_CH      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int BASE_DELAY  = 35,
   parameter int STAGGER     = 8,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic          clk_i,
   input  logic          rst_i,
   lscc_rst_seq_if.slave bus
);
   localparam int D_LAST = BASE_DELAY + (NUM_CH - 1) * STAGGER;
   localparam int CNT_W  = (D_LAST > 0) ? $clog2(D_LAST + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(D_LAST);

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_COUNT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_rst;
   state_t                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic [NUM_CH-1:0]      rel_d;
   logic [NUM_CH-1:0]      rst_q;
   logic [NUM_CH-1:0]      rst_n_q;
   logic                   done_q;
   logic                   last_d;
   logic                   restart;

   // Preset-by-reset chain; only the deassertion of rst_i is synchronised.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
      end
   end

   assign sync_rst = sync_q[SYNC_STAGES-1];

   // Count value that the next edge will load; RESET always starts a run from zero.
   always_comb begin
      cnt_d = '0;
      if (state_q != ST_RESET) begin
         cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CNT_W'(1);
      end
   end

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      localparam int D_K = BASE_DELAY + gi * STAGGER;
      if (D_K == 0) begin : g_immediate
         assign rel_d[gi] = 1'b1;
      end else begin : g_delayed
         assign rel_d[gi] = (cnt_d >= CNT_W'(D_K));
      end
   end

   // Delays are monotonic in channel index, so the last channel decides completion.
   assign last_d  = rel_d[NUM_CH-1];
   assign restart = (state_q == ST_RESET) ? bus.hold_i
                                          : (bus.hold_i || bus.soft_rst_i);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_RESET;
         cnt_q   <= '0;
         rst_q   <= '1;
         rst_n_q <= '0;
         done_q  <= 1'b0;
      end else if (sync_rst || restart) begin
         state_q <= ST_RESET;
         cnt_q   <= '0;
         rst_q   <= '1;
         rst_n_q <= '0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_RESET, ST_COUNT: begin
               state_q <= last_d ? ST_DONE : ST_COUNT;
               cnt_q   <= cnt_d;
               rst_q   <= ~rel_d;
               rst_n_q <= rel_d;
               done_q  <= last_d;
            end
            ST_DONE: begin
               state_q <= ST_DONE;
               rst_q   <= '0;
               rst_n_q <= '1;
               done_q  <= 1'b1;
            end
            default: begin
               state_q <= ST_RESET;
               cnt_q   <= '0;
               rst_q   <= '1;
               rst_n_q <= '0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rst_o   = rst_q;
   assign bus.rst_n_o = rst_n_q;
   assign bus.done_o  = done_q;

   if (TIMEOUT_CYC > 0) begin : g_wd
      localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
      localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC);
      logic [WD_W-1:0] wd_q;
      logic            timeout_q;
      logic            wd_run;

      assign wd_run = !sync_rst && (state_q != ST_DONE);

      // Saturating counter; the flag is sticky until rst_i.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
         end else begin
            if (!wd_run) begin
               wd_q <= '0;
            end else if (wd_q != WD_LIMIT) begin
               wd_q <= wd_q + WD_W'(1);
            end
            if (wd_run && (wd_q == WD_LIMIT - WD_W'(1))) begin
               timeout_q <= 1'b1;
            end
         end
      end

      assign bus.timeout_o = timeout_q;
   end else begin : g_no_wd
      assign bus.timeout_o = 1'b0;
   end
endmodule

// File: tb/tb_lscc_rst_seq.sv
// Bench for lscc_rst_seq: three parameterisations against a timestamp-based release model,
// plus directed checks of the release edges, hold/soft retrigger, watchdog and async reset.
module tb_lscc_rst_seq;
   logic clk;
   logic rst_v  [3];
   logic hold_v [3];
   logic soft_v [3];
   int   vectors;
   int   miscompares;

   int p_n  [3] = '{4, 4, 1};
   int p_s  [3] = '{2, 2, 3};
   int p_b  [3] = '{35, 35, 0};
   int p_st [3] = '{8, 8, 0};
   int p_t  [3] = '{1000000, 50, 0};

   typedef struct {
      int edge_n;
      int start;
      bit running;
      int wd;
      bit to;
      bit done;
   } model_t;
   model_t m [3];

   lscc_rst_seq_if #(.NUM_CH(4)) if_a ();
   lscc_rst_seq_if #(.NUM_CH(4)) if_b ();
   lscc_rst_seq_if #(.NUM_CH(1)) if_c ();

   assign if_a.hold_i = hold_v[0];
   assign if_a.soft_rst_i = soft_v[0];
   assign if_b.hold_i = hold_v[1];
   assign if_b.soft_rst_i = soft_v[1];
   assign if_c.hold_i = hold_v[2];
   assign if_c.soft_rst_i = soft_v[2];

   lscc_rst_seq dut_a (.clk_i(clk), .rst_i(rst_v[0]), .bus(if_a));
   lscc_rst_seq #(.NUM_CH(4), .SYNC_STAGES(2), .BASE_DELAY(35), .STAGGER(8), .TIMEOUT_CYC(50))
      dut_b (.clk_i(clk), .rst_i(rst_v[1]), .bus(if_b));
   lscc_rst_seq #(.NUM_CH(1), .SYNC_STAGES(3), .BASE_DELAY(0), .STAGGER(0), .TIMEOUT_CYC(0))
      dut_c (.clk_i(clk), .rst_i(rst_v[2]), .bus(if_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors = vectors + 1;
      assert (obs === exp) else begin
         miscompares = miscompares + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mreset(input int id);
      m[id].edge_n  = 0;
      m[id].start   = 0;
      m[id].running = 1'b0;
      m[id].wd      = 0;
      m[id].to      = 1'b0;
      m[id].done    = 1'b0;
   endtask

   // A run starts at the first edge after sync release where hold is low; channel k
   // is free once D_k edges have passed since that start edge.
   task automatic model_edge(input int id, input logic h, input logic s);
      int dl;
      dl = p_b[id] + (p_n[id] - 1) * p_st[id];
      m[id].edge_n = m[id].edge_n + 1;
      if (m[id].edge_n - 1 < p_s[id]) begin
         m[id].running = 1'b0;
         m[id].wd = 0;
      end else begin
         if (m[id].done) m[id].wd = 0;
         else if (p_t[id] > 0 && m[id].wd < p_t[id]) m[id].wd = m[id].wd + 1;
         if (p_t[id] > 0 && m[id].wd == p_t[id]) m[id].to = 1'b1;
         if (m[id].running) begin
            if (h || s) m[id].running = 1'b0;
         end else if (!h) begin
            m[id].running = 1'b1;
            m[id].start = m[id].edge_n;
         end
      end
      m[id].done = m[id].running && (m[id].edge_n - m[id].start >= dl);
   endtask

   function automatic logic [15:0] exp_rst(input int id);
      logic [15:0] v;
      v = '0;
      for (int k = 0; k < p_n[id]; k++)
         v[k] = !(m[id].running && (m[id].edge_n - m[id].start >= p_b[id] + k * p_st[id]));
      return v;
   endfunction

   task automatic check(input int id, input string tag);
      logic [15:0] er, en, orr, on, msk;
      logic od, ot;
      msk = 16'((32'd1 << p_n[id]) - 32'd1);
      er = exp_rst(id);
      en = ~er & msk;
      case (id)
         0: begin orr = 16'(if_a.rst_o); on = 16'(if_a.rst_n_o); od = if_a.done_o; ot = if_a.timeout_o; end
         1: begin orr = 16'(if_b.rst_o); on = 16'(if_b.rst_n_o); od = if_b.done_o; ot = if_b.timeout_o; end
         default: begin orr = 16'(if_c.rst_o); on = 16'(if_c.rst_n_o); od = if_c.done_o; ot = if_c.timeout_o; end
      endcase
      cmp($sformatf("%s dut%0d E%0d rst_o", tag, id, m[id].edge_n), 32'(orr), 32'(er));
      cmp($sformatf("%s dut%0d E%0d rst_n_o", tag, id, m[id].edge_n), 32'(on), 32'(en));
      cmp($sformatf("%s dut%0d E%0d done_o", tag, id, m[id].edge_n), 32'(od), 32'(m[id].done));
      cmp($sformatf("%s dut%0d E%0d timeout_o", tag, id, m[id].edge_n), 32'(ot), 32'(m[id].to));
   endtask

   task automatic step(input int id);
      @(posedge clk);
      #1;
      model_edge(id, hold_v[id], soft_v[id]);
      check(id, "step");
   endtask

   task automatic run_to(input int id, input int n);
      while (m[id].edge_n < n) step(id);
   endtask

   task automatic release_rst(input int id);
      @(negedge clk);
      mreset(id);
      rst_v[id] = 1'b0;
   endtask

   // Called just after an edge: asserts rst_i mid-cycle and checks outputs with no clock.
   task automatic async_rst(input int id);
      #2;
      rst_v[id] = 1'b1;
      #1;
      mreset(id);
      check(id, "async");
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      for (int i = 0; i < 3; i++) begin
         rst_v[i] = 1'b1;
         hold_v[i] = 1'b0;
         soft_v[i] = 1'b0;
         mreset(i);
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) check(i, "reset");
      cmp("reset rst_o", 32'(if_a.rst_o), 32'hF);

      // Default release from power-on reset.
      release_rst(0);
      run_to(0, 37); cmp("A E37 rst_o", 32'(if_a.rst_o), 32'hF);
      run_to(0, 38); cmp("A E38 rst_o", 32'(if_a.rst_o), 32'hE);
      run_to(0, 46); cmp("A E46 rst_o", 32'(if_a.rst_o), 32'hC);
      run_to(0, 54); cmp("A E54 rst_o", 32'(if_a.rst_o), 32'h8);
      run_to(0, 61); cmp("A E61 done_o", 32'(if_a.done_o), 32'h0);
      run_to(0, 62); cmp("A E62 rst_o", 32'(if_a.rst_o), 32'h0);
      cmp("A E62 done_o", 32'(if_a.done_o), 32'h1);

      // Soft retrigger at T=100 while in DONE.
      run_to(0, 99);
      soft_v[0] = 1'b1;
      step(0);
      soft_v[0] = 1'b0;
      cmp("soft T rst_o", 32'(if_a.rst_o), 32'hF);
      cmp("soft T done_o", 32'(if_a.done_o), 32'h0);
      run_to(0, 135); cmp("soft T+35 rst_o", 32'(if_a.rst_o), 32'hF);
      run_to(0, 136); cmp("soft T+36 rst_o", 32'(if_a.rst_o), 32'hE);
      run_to(0, 159); cmp("soft T+59 done_o", 32'(if_a.done_o), 32'h0);
      run_to(0, 160); cmp("soft T+60 rst_o", 32'(if_a.rst_o), 32'h0);

      // Hold from E40 to E60.
      async_rst(0);
      release_rst(0);
      run_to(0, 40);
      hold_v[0] = 1'b1;
      run_to(0, 41); cmp("hold E41 rst_o", 32'(if_a.rst_o), 32'hF);
      run_to(0, 60);
      hold_v[0] = 1'b0;
      run_to(0, 95); cmp("hold E95 rst_o", 32'(if_a.rst_o), 32'hF);
      run_to(0, 96); cmp("hold E96 rst_o", 32'(if_a.rst_o), 32'hE);
      run_to(0, 120); cmp("hold E120 done_o", 32'(if_a.done_o), 32'h1);

      // Asynchronous reset with cnt at 40, then a clean re-release.
      async_rst(0);
      release_rst(0);
      run_to(0, 43);
      async_rst(0);
      cmp("async rst_o", 32'(if_a.rst_o), 32'hF);
      cmp("async done_o", 32'(if_a.done_o), 32'h0);
      release_rst(0);
      run_to(0, 37); cmp("rerun E37 rst_o", 32'(if_a.rst_o), 32'hF);
      run_to(0, 38); cmp("rerun E38 rst_o", 32'(if_a.rst_o), 32'hE);
      run_to(0, 62); cmp("rerun E62 done_o", 32'(if_a.done_o), 32'h1);

      // Random hold/soft traffic on the default configuration.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 79) == 0) hold_v[0] = ~hold_v[0];
         soft_v[0] = ($urandom_range(0, 149) == 0);
         step(0);
      end
      hold_v[0] = 1'b0;
      soft_v[0] = 1'b0;
      async_rst(0);

      // Watchdog: hold from reset, limit 50.
      hold_v[1] = 1'b1;
      release_rst(1);
      run_to(1, 51); cmp("wd E51 timeout_o", 32'(if_b.timeout_o), 32'h0);
      run_to(1, 52); cmp("wd E52 timeout_o", 32'(if_b.timeout_o), 32'h1);
      run_to(1, 80);
      hold_v[1] = 1'b0;
      run_to(1, 145);
      cmp("wd done_o", 32'(if_b.done_o), 32'h1);
      cmp("wd sticky timeout_o", 32'(if_b.timeout_o), 32'h1);
      soft_v[1] = 1'b1;
      step(1);
      soft_v[1] = 1'b0;
      run_to(1, 160);
      cmp("wd soft timeout_o", 32'(if_b.timeout_o), 32'h1);
      async_rst(1);
      cmp("wd rst timeout_o", 32'(if_b.timeout_o), 32'h0);

      // Single channel, zero delays, three sync stages, no watchdog.
      release_rst(2);
      run_to(2, 3);
      cmp("c E3 rst_o", 32'(if_c.rst_o), 32'h1);
      cmp("c E3 done_o", 32'(if_c.done_o), 32'h0);
      run_to(2, 4);
      cmp("c E4 rst_o", 32'(if_c.rst_o), 32'h0);
      cmp("c E4 done_o", 32'(if_c.done_o), 32'h1);
      hold_v[2] = 1'b1;
      run_to(2, 304);
      cmp("c hold timeout_o", 32'(if_c.timeout_o), 32'h0);
      hold_v[2] = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) == 0) hold_v[2] = ~hold_v[2];
         soft_v[2] = ($urandom_range(0, 7) == 0);
         step(2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
